// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, LSB first, one bit per clock.
// Operands and the initial borrow are latched on the accepting edge. The
// full-subtractor cell then runs WIDTH times with its borrow kept in a flop.
// diff/bout only update on the completion edge, so no partial result is ever visible.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   res_sr;
  logic               br;
  logic [CNT_W-1:0]   cnt;

  logic               bit_d;
  logic               bit_br;
  logic [WIDTH-1:0]   res_next;
  logic               last_bit;

  // Full-subtractor cell on the current LSBs, plus the result with the new bit shifted in at the MSB
  always_comb begin
    bit_d    = a_sr[0] ^ b_sr[0] ^ br;
    bit_br   = (~a_sr[0] & b_sr[0]) | (~a_sr[0] & br) | (b_sr[0] & br);
    res_next = {bit_d, res_sr[WIDTH-1:1]};
    last_bit = (cnt == CNT_W'(WIDTH - 1));
  end

  // Control FSM and datapath; DONE accepts start exactly like IDLE so back-to-back runs have no bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            br     <= bin;
            res_sr <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          br     <= bit_br;
          res_sr <= res_next;
          cnt    <= cnt + CNT_W'(1);
          if (last_bit) begin
            diff  <= res_next;
            bout  <= bit_br;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of serial_subtractor at WIDTH=8 and WIDTH=13.
// Expected results come from an integer model and are queued when stimulus is driven.
// They are popped and compared when the DUT raises done.
module tb_serial_subtractor;

  localparam int W8  = 8;
  localparam int W13 = 13;

  typedef struct {
    logic [15:0] diff;
    logic        bout;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic           start8, bin8, busy8, done8, bout8;
  logic [W8-1:0]  a8, b8, diff8;
  logic           start13, bin13, busy13, done13, bout13;
  logic [W13-1:0] a13, b13, diff13;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_subtractor #(.WIDTH(W13)) dut13 (
    .clk(clk), .rst(rst), .start(start13), .a(a13), .b(b13), .bin(bin13),
    .busy(busy13), .done(done13), .diff(diff13), .bout(bout13)
  );

  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b, input logic bin);
    exp_t e;
    int   mask;
    int   v;
    mask   = (1 << w) - 1;
    v      = (int'(a) & mask) - (int'(b) & mask) - int'(bin);
    e.diff = 16'(v & mask);
    e.bout = (v < 0);
    return e;
  endfunction

  function automatic logic cur_done(input int sel);
    return (sel != 0) ? done13 : done8;
  endfunction

  function automatic logic cur_busy(input int sel);
    return (sel != 0) ? busy13 : busy8;
  endfunction

  function automatic logic [15:0] cur_diff(input int sel);
    return (sel != 0) ? {3'b000, diff13} : {8'h00, diff8};
  endfunction

  function automatic logic cur_bout(input int sel);
    return (sel != 0) ? bout13 : bout8;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic [15:0] a, input logic [15:0] b, input logic bin, input logic st);
    if (sel != 0) begin
      a13 = a[W13-1:0]; b13 = b[W13-1:0]; bin13 = bin; start13 = st;
    end else begin
      a8 = a[W8-1:0]; b8 = b[W8-1:0]; bin8 = bin; start8 = st;
    end
  endtask

  // Drive one start pulse, queue its expected result and step past the accepting edge
  task automatic applyStimulus(input int sel, input logic [15:0] a, input logic [15:0] b, input logic bin);
    drive(sel, a, b, bin, 1'b1);
    sb.push_back(model((sel != 0) ? W13 : W8, a, b, bin));
    tick();
    drive(sel, a, b, bin, 1'b0);
  endtask

  task automatic wait_done(input int sel, input int budget, output int cycles, output bit stable);
    logic [15:0] d0;
    d0     = cur_diff(sel);
    stable = 1'b1;
    cycles = 0;
    while (!cur_done(sel) && cycles < budget) begin
      tick();
      cycles++;
      if (!cur_done(sel) && cur_diff(sel) !== d0) stable = 1'b0;
    end
    if (!cur_done(sel)) checkOutput("done_timeout", {15'd0, cur_done(sel)}, 16'd1);
  endtask

  task automatic check_result(input int sel, input string tag);
    exp_t e;
    checkOutput({tag, "_sb_nonempty"}, 16'(sb.size() != 0), 16'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checkOutput({tag, "_diff"}, cur_diff(sel), e.diff);
      checkOutput({tag, "_bout"}, {15'd0, cur_bout(sel)}, {15'd0, e.bout});
    end
  endtask

  task automatic run_op(input int sel, input logic [15:0] a, input logic [15:0] b, input logic bin, input string tag);
    int w;
    int cyc;
    bit st;
    w = (sel != 0) ? W13 : W8;
    applyStimulus(sel, a, b, bin);
    wait_done(sel, w + 4, cyc, st);
    checkOutput({tag, "_latency"}, 16'(cyc), 16'(w));
    check_result(sel, tag);
    checkOutput({tag, "_stable"}, {15'd0, st}, 16'd1);
  endtask

  task automatic expect_no_done(input int sel, input int n, input string tag);
    int cnt;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (cur_done(sel)) cnt++;
    end
    checkOutput(tag, 16'(cnt), 16'd0);
  endtask

  initial begin
    int cyc;
    bit st;
    exp_t junk;

    rst = 1'b1;
    drive(0, 16'h0, 16'h0, 1'b0, 1'b0);
    drive(1, 16'h0, 16'h0, 1'b0, 1'b0);
    #1;
    checkOutput("reset_busy", {15'd0, busy8}, 16'd0);
    checkOutput("reset_done", {15'd0, done8}, 16'd0);
    checkOutput("reset_diff", cur_diff(0), 16'h0);
    checkOutput("reset_bout", {15'd0, bout8}, 16'd0);
    #12 rst = 1'b0;
    tick();

    // Basic operation with latency, busy and done-pulse width checks
    applyStimulus(0, 16'h5A, 16'h3C, 1'b0);
    checkOutput("basic_busy", {15'd0, busy8}, 16'd1);
    wait_done(0, W8 + 4, cyc, st);
    checkOutput("basic_latency", 16'(cyc), 16'(W8));
    check_result(0, "basic");
    tick();
    checkOutput("basic_done_low", {15'd0, done8}, 16'd0);
    checkOutput("basic_busy_low", {15'd0, busy8}, 16'd0);
    checkOutput("basic_diff_held", cur_diff(0), 16'h1E);

    // Borrow and wrap corners
    run_op(0, 16'h00, 16'h01, 1'b0, "wrap_0m1");
    run_op(0, 16'h10, 16'h10, 1'b1, "eq_bin");
    run_op(0, 16'hFF, 16'h00, 1'b1, "ff_bin");

    // A start pulse while busy must be ignored
    applyStimulus(0, 16'h80, 16'h01, 1'b0);
    tick();
    tick();
    drive(0, 16'h00, 16'hFF, 1'b0, 1'b1);
    tick();
    drive(0, 16'h00, 16'hFF, 1'b0, 1'b0);
    wait_done(0, W8 + 4, cyc, st);
    checkOutput("busy_ign_latency", 16'(cyc), 16'd5);
    check_result(0, "busy_ign");
    expect_no_done(0, 12, "busy_ign_no_second_done");

    // Back-to-back with start held high, operands switched during the DONE cycle
    drive(0, 16'h05, 16'h03, 1'b0, 1'b1);
    sb.push_back(model(W8, 16'h05, 16'h03, 1'b0));
    tick();
    wait_done(0, W8 + 4, cyc, st);
    checkOutput("b2b_first_latency", 16'(cyc), 16'(W8));
    drive(0, 16'h03, 16'h05, 1'b0, 1'b1);
    sb.push_back(model(W8, 16'h03, 16'h05, 1'b0));
    check_result(0, "b2b_first");
    tick();
    wait_done(0, W8 + 4, cyc, st);
    checkOutput("b2b_spacing", 16'(cyc + 1), 16'(W8 + 1));
    drive(0, 16'h03, 16'h05, 1'b0, 1'b0);
    check_result(0, "b2b_second");
    tick();
    checkOutput("b2b_done_low", {15'd0, done8}, 16'd0);
    checkOutput("b2b_idle", {15'd0, busy8}, 16'd0);

    // Asynchronous reset in the middle of an operation
    applyStimulus(0, 16'hAA, 16'h55, 1'b0);
    tick();
    tick();
    tick();
    #3 rst = 1'b1;
    #1;
    checkOutput("midrst_busy", {15'd0, busy8}, 16'd0);
    checkOutput("midrst_done", {15'd0, done8}, 16'd0);
    checkOutput("midrst_diff", cur_diff(0), 16'h0);
    checkOutput("midrst_bout", {15'd0, bout8}, 16'd0);
    if (sb.size() != 0) junk = sb.pop_front();
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    expect_no_done(0, 12, "midrst_no_done");
    run_op(0, 16'h09, 16'h04, 1'b0, "after_rst");

    // Random operands, both widths
    for (int i = 0; i < 1000; i++)
      run_op(0, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), "rand8");
    for (int i = 0; i < 1000; i++)
      run_op(1, 16'($urandom_range(0, 8191)), 16'($urandom_range(0, 8191)), 1'($urandom_range(0, 1)), "rand13");
    checkOutput("idle13_busy", {15'd0, cur_busy(1)}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial multi-bit subtractor. It latches two WIDTH-bit operands and an initial borrow, then processes them LSB-first, one bit per clock. Each bit step applies the team's full-subtractor cell equations, with the borrow held in a flip-flop between cycles. It sits directly around the single-bit full-subtractor stage: it feeds that stage one bit pair per cycle and consumes its difference and borrow outputs, trading latency for area against a ripple subtractor.

Parameters:
WIDTH, 8, operand/result width in bits; legal range ≥ 2.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request to begin a subtraction; sampled on rising clk.
a  input  WIDTH  minuend; sampled only on the edge that accepts start.
b  input  WIDTH  subtrahend; sampled only on the edge that accepts start.
bin  input  1  initial borrow-in; sampled only on the edge that accepts start.
busy  output  1  high while bits are being processed (SHIFT state).
done  output  1  one-cycle pulse: diff/bout valid and newly updated.
diff  output  WIDTH  result a − b − bin modulo 2^WIDTH; held until the next completion.
bout  output  1  final borrow-out; 1 when a < b + bin (unsigned).

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, diff=0, bout=0; internal operand shift registers, borrow flop and bit counter cleared. Takes effect immediately, without a clock edge.
- Reset mid-operation: the operation is aborted; no done pulse; diff/bout read 0 after reset.
- States: IDLE, SHIFT, DONE. All outputs are registered.
- IDLE: busy=0, done=0. If start=1 at an edge:
  - latch a, b and bin into the shift registers and borrow flop;
  - clear counter;
  - next state SHIFT.
- SHIFT: busy=1. Each edge does the following:
  - bit d = a0 ^ b0 ^ br;
  - next br = (~a0 & b0) | (~a0 & br) | (b0 & br), where a0/b0 are the current LSBs;
  - d shifts into the result register from the MSB side, and the operand registers shift right;
  - counter increments.
- SHIFT completion: on the edge processing bit WIDTH−1:
  - diff ← completed result, bout ← final borrow;
  - done ← 1, busy ← 0;
  - next state DONE.
- DONE: done=1 for exactly this one cycle. start=1 at the DONE edge is accepted exactly as in IDLE (back-to-back operation, no idle bubble). Otherwise next state is IDLE and done returns to 0.
- Latency: start accepted at edge N; done=1 and diff/bout valid in the cycle following edge N+WIDTH. Throughput is one result per WIDTH+1 cycles when back-to-back.
- start while busy=1: ignored. Operands are not re-sampled and the in-flight operation is unaffected.
- diff/bout change only on completion edges (or reset). They never show partial results.
- Arithmetic: unsigned; diff wraps modulo 2^WIDTH; bout equals the borrow out of the MSB.
- a, b and bin may change freely at any time except the accepting edge.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, bin=0, start 1 cycle → busy for 8 cycles; done pulse 8 cycles after accept edge; diff=0x1E, bout=0; done low the following cycle.
- Borrow/wrap cases:
  - a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1.
  - a=0x10, b=0x10, bin=1 → diff=0xFF, bout=1.
  - a=0xFF, b=0x00, bin=1 → diff=0xFE, bout=0.
- Ignore-while-busy: start with a=0x80, b=0x01; at cycle 3 pulse start with a=0x00, b=0xFF → single done, diff=0x7F, bout=0; the second request has no effect.
- Back-to-back: start held high continuously with a=0x05, b=0x03 then a=0x03, b=0x05 (operands switched on the DONE cycle) → done pulses 9 cycles apart; diff=0x02/bout=0, then diff=0xFE/bout=1.
- Reset mid-op: assert rst asynchronously (between edges) at cycle 4 of a=0xAA, b=0x55 → busy, done, diff and bout go 0 immediately; no done pulse ever appears. After release, a new start with a=0x09, b=0x04 → diff=0x05, bout=0.
- Randomised: 1000 random a, b, bin (WIDTH=8 and WIDTH=13) → diff and bout match (a − b − bin) mod 2^WIDTH and the unsigned borrow; diff stable between done pulses.
